// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: each stage ripples one SEG-bit
// segment and hands its carry, partial sum and remaining operand bits onward.
module pipelined_ripple_adder #(
  parameter int WIDTH = 24,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_param
    $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of SEG");
  end

  // Handshake: a beat moves on a port when valid && ready in the same cycle;
  // valid never depends on ready, and data is held while valid && !ready.
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic             accept;

  assign b_eff  = sub ? ~b : b;
  assign cin    = sub | ci;
  assign accept = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - (k + 1) * SEG;

    logic              v_q;
    logic              c_q;
    logic              ld;
    logic              adv;
    logic [LO+SEG-1:0] s_q;
    logic [LO+SEG-1:0] s_d;
    logic [SEG-1:0]    seg_a;
    logic [SEG-1:0]    seg_b;
    logic              seg_c;
    logic [SEG:0]      seg_sum;

    assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, seg_c};

    if (k == 0) begin : g_head
      assign ld    = accept;
      assign seg_a = a[SEG-1:0];
      assign seg_b = b_eff[SEG-1:0];
      assign seg_c = cin;
      assign s_d   = seg_sum[SEG-1:0];
    end else begin : g_body
      assign ld    = g_stg[k-1].adv;
      assign seg_a = g_stg[k-1].g_rem.ar_q[SEG-1:0];
      assign seg_b = g_stg[k-1].g_rem.br_q[SEG-1:0];
      assign seg_c = g_stg[k-1].c_q;
      assign s_d   = {seg_sum[SEG-1:0], g_stg[k-1].s_q};
    end

    // A stage may move on when downstream is empty or emptying this cycle.
    if (k == LAST) begin : g_tail
      assign adv = v_q && out_ready;
    end else begin : g_link
      assign adv = v_q && (!g_stg[k+1].v_q || g_stg[k+1].adv);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        if (ld) begin
          v_q <= 1'b1;
        end else if (adv) begin
          v_q <= 1'b0;
        end
        if (ld) begin
          c_q <= seg_sum[SEG];
          s_q <= s_d;
        end
      end
    end

    // Only operand bits not yet consumed travel with the beat.
    if (REM > 0) begin : g_rem
      logic [REM-1:0] ar_q;
      logic [REM-1:0] br_q;
      logic [REM-1:0] ar_d;
      logic [REM-1:0] br_d;

      if (k == 0) begin : g_src
        assign ar_d = a[WIDTH-1:SEG];
        assign br_d = b_eff[WIDTH-1:SEG];
      end else begin : g_src
        assign ar_d = g_stg[k-1].g_rem.ar_q[REM+SEG-1:SEG];
        assign br_d = g_stg[k-1].g_rem.br_q[REM+SEG-1:SEG];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ar_q <= '0;
          br_q <= '0;
        end else if (ld) begin
          ar_q <= ar_d;
          br_q <= br_d;
        end
      end
    end
  end

  // Carry into the MSB, recovered from the MSB sum bit and its operand bits.
  logic msb_c_q;
  logic msb_c_d;

  assign msb_c_d = g_stg[LAST].seg_a[SEG-1] ^ g_stg[LAST].seg_b[SEG-1]
                 ^ g_stg[LAST].seg_sum[SEG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_c_q <= 1'b0;
    end else if (g_stg[LAST].ld) begin
      msb_c_q <= msb_c_d;
    end
  end

  assign in_ready  = !g_stg[0].v_q || g_stg[0].adv;
  assign out_valid = g_stg[LAST].v_q;
  assign sum       = g_stg[LAST].s_q;
  assign co        = g_stg[LAST].c_q;
  assign ovf       = g_stg[LAST].c_q ^ msb_c_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed and streaming checks for pipelined_ripple_adder (24/4 and 8/8).
module tb_pipelined_ripple_adder;

  localparam int W   = 24;
  localparam int S   = 4;
  localparam int STG = W / S;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ci;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          co;
  logic          ovf;

  logic          in_valid8;
  logic          in_ready8;
  logic [7:0]    a8;
  logic [7:0]    b8;
  logic          ci8;
  logic          sub8;
  logic          out_valid8;
  logic [7:0]    sum8;
  logic          co8;
  logic          ovf8;

  int            checks;
  int            failures;
  int            out_cnt;
  logic          mon_en;
  logic          held_valid;
  logic [W+1:0]  held_val;
  logic [W+1:0]  exp_q[$];

  pipelined_ripple_adder #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .co(co), .ovf(ovf)
  );

  pipelined_ripple_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ci(ci8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(1'b1), .sum(sum8), .co(co8), .ovf(ovf8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic civ, input logic subv);
    logic [W-1:0] be;
    logic         c0;
    logic [W:0]   full;
    logic         o;
    be   = subv ? ~bv : bv;
    c0   = subv ? 1'b1 : civ;
    full = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, c0};
    o    = (av[W-1] == be[W-1]) && (full[W-1] != av[W-1]);
    return {o, full};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // driver: offer one beat from posedge+1, returns at posedge+1 after acceptance
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                      input logic subv, input logic [W+1:0] ev, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    ci       = civ;
    sub      = subv;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    else exp_q.push_back(ev);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int waited);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         civ;
    logic         subv;
    av   = W'($urandom);
    bv   = W'($urandom);
    civ  = 1'($urandom_range(0, 1));
    subv = 1'($urandom_range(0, 1));
    send(av, bv, civ, subv, model(av, bv, civ, subv), waited);
  endtask

  // called right after send() returns: counts edges from acceptance to out_valid
  task automatic measure_latency(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    check(tag, 64'(lat), 64'(exp_lat));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    sync();
  endtask

  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic civ,
                       input logic subv, input logic [9:0] ev);
    in_valid8 = 1'b1;
    a8        = av;
    b8        = bv;
    ci8       = civ;
    sub8      = subv;
    @(negedge clk);
    check("w8_in_ready", 64'(in_ready8), 64'd1);
    sync();
    in_valid8 = 1'b0;
    @(negedge clk);
    check("w8_out_valid", 64'(out_valid8), 64'd1);
    check("w8_result", 64'({ovf8, co8, sum8}), 64'(ev));
    sync();
  endtask

  // scoreboard: output handshakes pop the expected queue; stalled beats must hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (held_valid && out_valid) check("hold_stable", 64'({ovf, co, sum}), 64'(held_val));
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
        else check("result", 64'({ovf, co, sum}), 64'(exp_q.pop_front()));
      end
      held_valid = out_valid && !out_ready;
      held_val   = {ovf, co, sum};
    end
  end

  initial begin
    int w;
    int stalls;
    int cnt;
    int start;
    int guard;
    checks     = 0;
    failures   = 0;
    out_cnt    = 0;
    mon_en     = 1'b0;
    held_valid = 1'b0;
    held_val   = '0;
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    a          = 24'h123456;
    b          = 24'h654321;
    ci         = 1'b1;
    sub        = 1'b0;
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    a8         = '0;
    b8         = '0;
    ci8        = 1'b0;
    sub8       = 1'b0;

    // reset with a beat offered
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_co", 64'(co), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    mon_en = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("no_spurious_after_rst", 64'(cnt), 64'd0);
    sync();

    // directed vectors
    send(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, {1'b0, 1'b1, 24'h000000}, w);
    measure_latency("latency_add", STG);
    drain("drain_add1");
    send(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, {1'b1, 1'b0, 24'h800000}, w);
    send(24'h000010, 24'h000020, 1'b1, 1'b0, {1'b0, 1'b0, 24'h000031}, w);
    send(24'h000005, 24'h000007, 1'b1, 1'b1, {1'b0, 1'b0, 24'hFFFFFE}, w);
    send(24'h800000, 24'h000001, 1'b0, 1'b1, {1'b1, 1'b1, 24'h7FFFFF}, w);
    send(24'h000100, 24'h000001, 1'b0, 1'b1, {1'b0, 1'b1, 24'h0000FF}, w);
    drain("drain_directed");

    // streaming at full rate
    stalls = 0;
    start  = out_cnt;
    for (int i = 0; i < 200; i++) begin
      send_rand(w);
      stalls += w;
    end
    check("stream_stalls", 64'(stalls), 64'd0);
    drain("drain_stream");
    check("stream_count", 64'(out_cnt - start), 64'd200);

    // backpressure
    start = out_cnt;
    fork
      begin
        for (int i = 0; i < 100; i++) send_rand(w);
      end
      begin
        out_ready = 1'b0;
        repeat (10) sync();
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        guard = 0;
        while (out_cnt - start < 100 && guard < 3000) begin
          out_ready = 1'($urandom_range(0, 1));
          sync();
          guard++;
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    check("bp_count", 64'(out_cnt - start), 64'd100);

    // reset while beats are in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(w);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_sum", 64'(sum), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("no_ghost_after_rst", 64'(cnt), 64'd0);
    sync();
    send(24'h000ABC, 24'h000123, 1'b0, 1'b0, {1'b0, 1'b0, 24'h000BDF}, w);
    measure_latency("latency_after_rst", STG);
    drain("drain_after_rst");

    // single-stage instance
    send8(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    send8(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
    send8(8'h03, 8'h05, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE});
    send8(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined ripple-carry adder/subtractor for the adder datapath family. Operands split into SEG-bit segments; each pipeline stage ripples one segment, passing carry to the next stage through a register. Valid/ready handshake on both sides sustains one operation per cycle with full backpressure. Sits where wide adders (24 bits and up) must close timing that a single combinational ripple chain cannot.

## Interface
- WIDTH, 24, operand/sum width in bits; must be a multiple of SEG (elaboration error otherwise)
- SEG, 4, bits rippled per pipeline stage; STAGES = WIDTH/SEG (STAGES = 1 allowed)

- clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-low
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  operand A (two's complement or unsigned)
- b  input  WIDTH  operand B
- ci  input  1  carry-in (add mode only)
- sub  input  1  1 = subtract A-B, 0 = add A+B+ci
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- co  output  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- Accept when in_valid && in_ready. Effective operands: add -> a, b, cin=ci; sub -> a, ~b, cin=1 (ci ignored).
- Stage k (0..STAGES-1) holds: valid bit, sum bits [k*SEG+SEG-1:0] computed so far, carry into segment k+1, remaining upper a/b-effective bits, and (last stage only) carry into MSB for ovf.
- Stage 0 computes segment 0 from the accepted beat; stage k+1 computes segment k+1 from stage k registers plus stage k carry. Upper operand bits shift along unchanged; consumed bits need not be kept.
- Advance rules: adv[last] = valid[last] && out_ready; adv[k] = valid[k] && (!valid[k+1] || adv[k+1]). Stage k+1 loads on adv[k]; a stage whose beat leaves without reload clears its valid.
- in_ready = !valid[0] || adv[0] (combinational, no bubble when the pipe drains at full rate).
- out_valid = valid[last]; sum/co/ovf driven from last-stage registers, stable while out_valid && !out_ready.
- Results leave in acceptance order; no drop, no duplication.
- Arithmetic: result is (a + b_eff + cin) mod 2^WIDTH; co = bit WIDTH of the full sum.

## Timing
- Reset (asynchronous, immediate): all valid bits 0, all data/carry registers 0. Outputs: out_valid=0, sum=0, co=0, ovf=0; in_ready=1 once pipe empty (i.e. during and after reset).
- Latency: beat accepted at edge t -> out_valid high after edge t+STAGES-1... precisely: first visible on out_valid in the cycle after STAGES rising edges have elapsed since acceptance edge included (WIDTH=24, SEG=4: 6 cycles).
- Throughput: 1 beat/cycle when out_ready held high.
- Backpressure: out_ready low with full pipe -> in_ready=0 same cycle; pipe compresses bubbles while stalled (upstream stages still advance into empty slots).
- Simultaneous out handshake and in handshake with full pipe: both complete, occupancy unchanged.
- Reset mid-operation: all in-flight beats discarded; no result emitted after rst_n rises until a new beat is accepted and STAGES cycles elapse.
- sub/ci sampled only at acceptance; changing them later has no effect on in-flight beats.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, sum=0, co=0, ovf=0, in_ready=1; release, no spurious out_valid.
- Add carry ripple (WIDTH=24, SEG=4): a=24'hFFFFFF, b=24'h000001, ci=0, out_ready=1 -> sum=24'h000000, co=1, ovf=0, exactly 6 cycles after acceptance; also a=24'h7FFFFF, b=24'h000001 -> sum=24'h800000, co=0, ovf=1.
- Subtract: a=24'h000005, b=24'h000007, sub=1, ci=1 -> sum=24'hFFFFFE, co=0, ovf=0; a=24'h800000, b=24'h000001, sub=1 -> sum=24'h7FFFFF, co=1, ovf=1.
- Streaming: 200 random back-to-back beats (mixed sub/ci), out_ready=1 -> one result per cycle in order, matching reference model; repeat with WIDTH=32, SEG=8 and WIDTH=SEG=8.
- Backpressure: stream continuously, out_ready=0 for 10 cycles then random toggling -> in_ready=0 once 6 beats held, output beat held stable while stalled, no loss/duplication across 100 beats.
- Reset mid-flight: 3 beats in flight, pulse rst_n low asynchronously mid-cycle -> out_valid drops immediately, none of the 3 beats ever appear; next accepted beat returns correctly after 6 cycles.
